rng_coef_sampler: RTL and testbench
===================================

// Module: rng_coef_sampler
// PURPOSE
//  Downstream consumer of the simplerng random-word source. Turns raw RND_W-bit random words
//  into a counted stream of ring-LWE polynomial coefficients: uniform mod Q (rejection) or binary.
//  Sits between the RNG and the coefficient RAM / NTT-free binary-RLWE multiplier, paced by valid/ready.
// PARAMETERS
//  RND_W   32   random word width; must be a multiple of COEF_W
//  COEF_W  8    coefficient width in bits
//  Q       251  modulus for uniform mode; 2 <= Q <= 2**COEF_W
//  LEN_W   10   width of coefficient request count
// PORTS
//  clk        in   1       clock, all logic on rising edge
//  reset      in   1       synchronous, active-high
//  start      in   1       pulse: begin job (ignored unless state IDLE)
//  mode       in   1       0 = uniform mod Q, 1 = binary {0,1}; sampled on start
//  len        in   LEN_W   number of coefficients to emit; sampled on start
//  busy       out  1       high in any state other than IDLE
//  done       out  1       one-cycle pulse when the job completes
//  rej_cnt    out  16      rejected chunks since last start, saturating at 0xFFFF
//  rng_en     out  1       drives RNG enable; high only in FETCH
//  rng_wait   in   1       RNG busy; rng_data is a fresh word whenever rng_en & ~rng_wait
//  rng_data   in   RND_W   random word
//  out_valid  out  1       coefficient valid
//  out_ready  in   1       consumer accepts when out_valid & out_ready
//  out_data   out  COEF_W  coefficient, zero-extended in binary mode
// BEHAVIOUR
//  Reset: state IDLE; busy, done, rng_en, out_valid = 0; out_data, rej_cnt, word/chunk regs = 0.
//  Reset mid-job aborts it; no done pulse; pending coefficient dropped.
//  States: IDLE, FETCH, SPLIT, DRAIN, DONE.
//  IDLE: on start, latch mode/len, clear rej_cnt, rem <= len.
//   Goes to DONE if len==0 (no fetch, no output), else FETCH.
//  FETCH: rng_en=1. On a cycle with ~rng_wait: capture rng_data into shift reg, chunk index = 0, go SPLIT.
//   Each capture cycle is a distinct word; never capture without rng_en.
//  SPLIT: chunk = low COEF_W bits (uniform) or bit 0 (binary), consumed LSB first.
//   Slot free = ~out_valid | out_ready. If not free: stall, hold chunk.
//   If free, consume the chunk (shift the word).
//   Accept if binary, or if uniform and chunk < Q: load out_data, out_valid <= 1, rem <= rem-1.
//   Reject (chunk >= Q): rej_cnt++ (saturating); out_valid follows the handshake only.
//   Accept when rem==1: go DRAIN; remaining chunks are discarded.
//   Else, last chunk of the word (RND_W/COEF_W chunks uniform, RND_W binary): go FETCH.
//  DRAIN: when out_valid & out_ready, go DONE.
//  DONE: done=1 for exactly one cycle, then IDLE. busy=0 from the IDLE cycle.
//  Output register: out_valid clears on handshake unless reloaded the same cycle.
//   out_data is stable while out_valid & ~out_ready.
//  Latency: start in cycle 0 -> rng_en in cycle 1 -> word captured at end of cycle 1 (rng_wait=0)
//   -> SPLIT in cycle 2 -> first accepted coefficient has out_valid in cycle 3.
//   Best case one coefficient per cycle thereafter.
//  Output handshake continues during FETCH. Words are never requested in DRAIN, DONE or IDLE.
//  Never more than len coefficients per job. rng_wait held high keeps FETCH indefinitely (no timeout).
// TESTING
//  T1 uniform, len=2, rng_data=0xFC10FB05, out_ready=1 -> out 0x05, 0x10; rej_cnt=1 (0xFB);
//     0xFC discarded; done once.
//  T2 uniform, len=3, words 0xFFFFFFFF then 0x00000302 -> rej_cnt=4; out 0x02, 0x03, 0x00;
//     exactly 2 rng captures.
//  T3 binary, len=4, rng_data=0x0000000D -> out 1, 0, 1, 1; one capture; done.
//  T4 out_ready low for 5 cycles on the 1st coefficient -> out_data/out_valid held;
//     no chunk consumed; no loss or duplication after release.
//  T5 len=0 -> done pulse in cycle 1, rng_en never high, out_valid never high.
//  T6 rng_wait=1 for 10 cycles in FETCH, then reset mid-SPLIT -> all outputs at reset values;
//     no done; restart behaves as T1.

Source files
------------

// File: rtl/rng_coef_sampler_if.sv
// Handshake bundle between the coefficient sampler, its random-word source and the coefficient consumer.
// The sampler takes the master view; the RNG/consumer side (or a testbench) takes the slave view.
interface rng_coef_sampler_if #(
    parameter int RND_W  = 32,
    parameter int COEF_W = 8
);
    logic              rng_en;
    logic              rng_wait;
    logic [RND_W-1:0]  rng_data;
    logic              out_valid;
    logic              out_ready;
    logic [COEF_W-1:0] out_data;

    modport master (
        output rng_en, out_valid, out_data,
        input  rng_wait, rng_data, out_ready
    );

    modport slave (
        input  rng_en, out_valid, out_data,
        output rng_wait, rng_data, out_ready
    );
endinterface

// File: rtl/rng_coef_sampler.sv
// Splits raw random words into a counted stream of ring-LWE coefficients,
// either uniform mod Q by rejection sampling or binary {0,1}.
module rng_coef_sampler #(
    parameter int RND_W  = 32,
    parameter int COEF_W = 8,
    parameter int Q      = 251,
    parameter int LEN_W  = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    input  logic                mode_i,
    input  logic [LEN_W-1:0]    len_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [15:0]         rej_cnt_o,
    rng_coef_sampler_if.master  bus
);
    localparam int IDX_W = (RND_W > 1) ? $clog2(RND_W) : 1;
    localparam logic [IDX_W-1:0]  LAST_UNI = IDX_W'(RND_W / COEF_W - 1);
    localparam logic [IDX_W-1:0]  LAST_BIN = IDX_W'(RND_W - 1);
    localparam logic [COEF_W:0]   Q_LIM    = (COEF_W + 1)'(Q);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_SPLIT, S_DRAIN, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [RND_W-1:0]  word_q, word_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [15:0]       rej_q, rej_d;
    logic              valid_q, valid_d;
    logic [COEF_W-1:0] data_q, data_d;

    logic [COEF_W-1:0] chunk;
    logic              slot_free;
    logic              accept;
    logic              last_chunk;
    logic              rng_en;

    // Binary mode uses one bit per coefficient; uniform uses a whole COEF_W-bit chunk.
    assign chunk      = mode_q ? {{(COEF_W-1){1'b0}}, word_q[0]} : word_q[COEF_W-1:0];
    assign slot_free  = ~valid_q | bus.out_ready;
    assign accept     = mode_q | ({1'b0, chunk} < Q_LIM);
    assign last_chunk = (idx_q == (mode_q ? LAST_BIN : LAST_UNI));

    // NOTE: every _d gets its hold value first so no path through the case leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        word_d  = word_q;
        idx_d   = idx_q;
        rej_d   = rej_q;
        valid_d = valid_q;
        data_d  = data_q;
        rng_en  = 1'b0;

        // The output slot drains on every handshake, in any state; a SPLIT accept below reloads it.
        if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mode_d  = mode_i;
                    rem_d   = len_i;
                    rej_d   = '0;
                    state_d = (len_i == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                rng_en = 1'b1;
                if (!bus.rng_wait) begin
                    word_d  = bus.rng_data;
                    idx_d   = '0;
                    state_d = S_SPLIT;
                end
            end
            S_SPLIT: begin
                if (slot_free) begin
                    word_d = mode_q ? (word_q >> 1) : (word_q >> COEF_W);
                    idx_d  = idx_q + 1'b1;
                    if (accept) begin
                        data_d  = chunk;
                        valid_d = 1'b1;
                        rem_d   = rem_q - 1'b1;
                    end else if (rej_q != 16'hFFFF) begin
                        rej_d = rej_q + 16'd1;
                    end
                    if (accept && rem_q == LEN_W'(1)) begin
                        state_d = S_DRAIN;
                    end else if (last_chunk) begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_DRAIN: begin
                if (valid_q && bus.out_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            rem_q   <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            rej_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            rej_q   <= rej_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);
    assign rej_cnt_o     = rej_q;
    assign bus.rng_en    = rng_en;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
endmodule

// File: tb/tb_rng_coef_sampler.sv
// Directed, table-driven bench for rng_coef_sampler plus hand-written stall,
// rng_wait and mid-job reset sequences.
module tb_rng_coef_sampler;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       mode;
    logic [9:0] len;
    logic       busy;
    logic       done;
    logic [15:0] rej_cnt;

    rng_coef_sampler_if #(.RND_W(32), .COEF_W(8)) bus ();

    rng_coef_sampler #(.RND_W(32), .COEF_W(8), .Q(251), .LEN_W(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start_i   (start),
        .mode_i    (mode),
        .len_i     (len),
        .busy_o    (busy),
        .done_o    (done),
        .rej_cnt_o (rej_cnt),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic            mode;
        logic [9:0]      len;
        logic [31:0]     w0;
        logic [31:0]     w1;
        int              n;
        logic [3:0][7:0] exp;
        int              rej;
        int              caps;
        int              stall;
        int              waitc;
    } vec_t;

    vec_t vecs [7];

    // Per-job observations filled by run_job.
    logic [7:0]  got [$];
    logic [31:0] words [2];
    int caps, dones, done_cyc, first_valid_cyc;
    bit rng_en_seen, ovalid_seen;

    task automatic run_job(input logic m, input logic [9:0] l, input int stall, input int waitc);
        int stall_left = stall;
        int wait_left  = waitc;
        int widx       = 0;
        logic [7:0] held = '0;
        got.delete();
        caps = 0; dones = 0; done_cyc = -1; first_valid_cyc = -1;
        rng_en_seen = 0; ovalid_seen = 0;
        @(negedge clk);
        mode = m; len = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (bus.rng_en) rng_en_seen = 1;
            if (bus.out_valid) begin
                ovalid_seen = 1;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
                break;
            end
            bus.rng_wait = (bus.rng_en && wait_left > 0);
            if (bus.rng_wait) wait_left--;
            bus.rng_data = words[(widx < 2) ? widx : 1];
            if (bus.out_valid && stall_left > 0) begin
                if (stall_left < stall) check("stall_hold_data", bus.out_data, held);
                held = bus.out_data;
                stall_left--;
                bus.out_ready = 1'b0;
            end else begin
                bus.out_ready = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
            if (bus.rng_en && !bus.rng_wait) begin
                caps++;
                widx++;
            end
            @(negedge clk);
        end
        bus.rng_wait = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        vecs[0] = '{1'b0, 10'd2, 32'hFC10FB05, 32'h0, 2, {8'h0, 8'h0, 8'h10, 8'h05}, 1, 1, 0, 0};
        vecs[1] = '{1'b0, 10'd3, 32'hFFFFFFFF, 32'h00000302, 3, {8'h0, 8'h00, 8'h03, 8'h02}, 4, 2, 0, 0};
        vecs[2] = '{1'b1, 10'd4, 32'h0000000D, 32'h0, 4, {8'h01, 8'h01, 8'h00, 8'h01}, 0, 1, 0, 0};
        vecs[3] = '{1'b0, 10'd2, 32'hFC10FB05, 32'h0, 2, {8'h0, 8'h0, 8'h10, 8'h05}, 1, 1, 5, 0};
        vecs[4] = '{1'b0, 10'd0, 32'hFC10FB05, 32'h0, 0, {8'h0, 8'h0, 8'h0, 8'h0}, 0, 0, 0, 0};
        vecs[5] = '{1'b0, 10'd2, 32'h00FBFAFB, 32'h0, 2, {8'h0, 8'h0, 8'h00, 8'hFA}, 2, 1, 0, 0};
        vecs[6] = '{1'b0, 10'd4, 32'h04030201, 32'h0, 4, {8'h04, 8'h03, 8'h02, 8'h01}, 0, 1, 0, 3};

        reset = 1'b1; start = 1'b0; mode = 1'b0; len = '0;
        bus.rng_wait = 1'b0; bus.rng_data = '0; bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'b0, busy}, 0);
        check("reset_done", {31'b0, done}, 0);
        check("reset_rng_en", {31'b0, bus.rng_en}, 0);
        check("reset_out_valid", {31'b0, bus.out_valid}, 0);
        check("reset_out_data", {24'b0, bus.out_data}, 0);
        check("reset_rej_cnt", {16'b0, rej_cnt}, 0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            words[0] = vecs[i].w0;
            words[1] = vecs[i].w1;
            run_job(vecs[i].mode, vecs[i].len, vecs[i].stall, vecs[i].waitc);
            check($sformatf("v%0d_done_cnt", i), dones, 1);
            check($sformatf("v%0d_out_cnt", i), got.size(), vecs[i].n);
            for (int k = 0; k < vecs[i].n && k < got.size(); k++)
                check($sformatf("v%0d_out%0d", i, k), {24'b0, got[k]}, {24'b0, vecs[i].exp[k]});
            check($sformatf("v%0d_rej_cnt", i), {16'b0, rej_cnt}, vecs[i].rej);
            check($sformatf("v%0d_captures", i), caps, vecs[i].caps);
            if (i == 0) check("v0_first_valid_cycle", first_valid_cyc, 2);
            if (vecs[i].len == 0) begin
                check("len0_done_cycle", done_cyc, 0);
                check("len0_rng_en_seen", {31'b0, rng_en_seen}, 0);
                check("len0_out_valid_seen", {31'b0, ovalid_seen}, 0);
            end
            @(negedge clk);
            check($sformatf("v%0d_done_pulse_once", i), {31'b0, done}, 0);
            check($sformatf("v%0d_idle_busy", i), {31'b0, busy}, 0);
        end

        // rng_wait holds FETCH, then reset lands mid-SPLIT.
        begin
            int en_cnt = 0;
            int done_seen = 0;
            @(negedge clk);
            mode = 1'b0; len = 10'd2; start = 1'b1; bus.rng_wait = 1'b1; bus.out_ready = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int c = 0; c < 10; c++) begin
                if (bus.rng_en && busy) en_cnt++;
                @(negedge clk);
            end
            check("wait_fetch_held", en_cnt, 10);
            bus.rng_wait = 1'b0;
            bus.rng_data = 32'hFC10FB05;
            @(negedge clk);
            bus.rng_wait = 1'b1;
            @(negedge clk);
            check("mid_split_out_valid", {31'b0, bus.out_valid}, 1);
            check("mid_split_out_data", {24'b0, bus.out_data}, 32'h05);
            reset = 1'b1;
            @(negedge clk);
            check("abort_busy", {31'b0, busy}, 0);
            check("abort_rng_en", {31'b0, bus.rng_en}, 0);
            check("abort_out_valid", {31'b0, bus.out_valid}, 0);
            check("abort_out_data", {24'b0, bus.out_data}, 0);
            check("abort_rej_cnt", {16'b0, rej_cnt}, 0);
            reset = 1'b0;
            bus.rng_wait = 1'b0;
            for (int c = 0; c < 5; c++) begin
                if (done) done_seen++;
                @(negedge clk);
            end
            check("abort_no_done", done_seen, 0);
        end

        words[0] = 32'hFC10FB05;
        words[1] = 32'h0;
        run_job(1'b0, 10'd2, 0, 0);
        check("restart_done_cnt", dones, 1);
        check("restart_out_cnt", got.size(), 2);
        if (got.size() == 2) begin
            check("restart_out0", {24'b0, got[0]}, 32'h05);
            check("restart_out1", {24'b0, got[1]}, 32'h10);
        end
        check("restart_rej_cnt", {16'b0, rej_cnt}, 1);
        check("restart_captures", caps, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
